match_ctrl: RTL and testbench

- Round/match sequencer for the physics engine.
- Paces physics updates to the video frame rate and holds physics in reset between rounds.
- Gates player inputs, keeps the score and decides the match winner.
- Sits between the frame-timing/input front end and the physics engine; its score/state outputs drive the renderer HUD.

---
 rtl/pika_pkg.sv | 27 ++
 rtl/frame_down_counter.sv | 30 +++
 rtl/match_ctrl.sv | 171 +++++++++++++++++
 tb/tb_match_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pika_pkg.sv
// Shared types and constants for the match sequencer.
// State encoding is visible on the HUD/debug port.
package pika_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_STEP  = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam int SCORE_W = 4;
    localparam int CNT_W   = 8;

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] s
    );
        return (s == '1) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable frame-tick down counter shared by serve and point pauses.
// o_expire fires on the tick that reaches zero, or at once if already zero.
module frame_down_counter
    import pika_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && i_tick && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expire = i_en &&
        ((r_cnt == '0) || (i_tick && r_cnt == CNT_W'(1)));

endmodule

// File: rtl/match_ctrl.sv
// Round/match sequencer: paces physics steps, gates inputs, keeps score.
// Build option MATCH_DEUCE_EN: win needs a two-point lead (15 wins outright).
module match_ctrl #(
    parameter int WIN_SCORE     = 7,
    parameter int SERVE_FRAMES  = 60,
    parameter int PAUSE_FRAMES  = 90,
    parameter int VALID_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       phys_valid,
    input  logic       phys_game_over,
    input  logic [1:0] phys_winner,
    output logic       phys_en,
    output logic       phys_rst_n,
    output logic       ops_allow,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] match_winner,
    output logic [2:0] state_o,
    output logic       err
);
    import pika_pkg::*;

    state_t             r_state, w_next;
    logic               r_start_d;
    logic [SCORE_W-1:0] r_p1, r_p2, w_p1, w_p2;
    logic [1:0]         r_winner, w_winner;
    logic [1:0]         r_scorer, w_scorer;
    logic               r_err, w_err;
    logic [CNT_W-1:0]   r_to, w_to;
    logic               r_phys_en, w_phys_en;
    logic               r_phys_rst_n, r_ops;
    logic               w_rise, w_cnt_load, w_cnt_en, w_expire, w_win;
    logic [CNT_W-1:0]   w_cnt_val;
    logic [SCORE_W-1:0] w_s;

    assign w_rise   = start_btn & ~r_start_d;
    assign w_cnt_en = (r_state == ST_SERVE) || (r_state == ST_POINT);
    assign w_s      = (r_scorer == WIN_P1) ? r_p1 : r_p2;

`ifdef MATCH_DEUCE_EN
    logic [SCORE_W-1:0] w_o;
    assign w_o   = (r_scorer == WIN_P1) ? r_p2 : r_p1;
    assign w_win = (w_s == '1) ||
        ((w_s >= SCORE_W'(WIN_SCORE)) &&
         ({1'b0, w_s} >= {1'b0, w_o} + 5'd2));
`else
    assign w_win = w_s >= SCORE_W'(WIN_SCORE);
`endif

    frame_down_counter u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_cnt_en),
        .i_tick     (frame_tick),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_next     = r_state;
        w_p1       = r_p1;
        w_p2       = r_p2;
        w_winner   = r_winner;
        w_scorer   = r_scorer;
        w_err      = r_err;
        w_to       = r_to;
        w_phys_en  = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_val  = CNT_W'(SERVE_FRAMES);
        unique case (r_state)
            ST_IDLE, ST_OVER: begin
                if (w_rise) begin
                    w_next     = ST_SERVE;
                    w_p1       = '0;
                    w_p2       = '0;
                    w_winner   = WIN_NONE;
                    w_err      = 1'b0;
                    w_cnt_load = 1'b1;
                end
            end
            ST_SERVE: begin
                if (w_expire) w_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    w_next    = ST_STEP;
                    w_phys_en = 1'b1;
                    w_to      = CNT_W'(VALID_TIMEOUT);
                end
            end
            ST_STEP: begin
                // valid wins over timeout; any tick here is dropped
                if (phys_valid) begin
                    w_next = ST_PLAY;
                    if (phys_game_over) begin
                        if (phys_winner == WIN_P1 || phys_winner == WIN_P2) begin
                            w_next     = ST_POINT;
                            w_scorer   = phys_winner;
                            w_cnt_load = 1'b1;
                            w_cnt_val  = CNT_W'(PAUSE_FRAMES);
                            if (phys_winner == WIN_P1) w_p1 = sat_inc(r_p1);
                            else                       w_p2 = sat_inc(r_p2);
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end else if (r_to == '0) begin
                    w_next = ST_PLAY;
                    w_err  = 1'b1;
                end else begin
                    w_to = r_to - CNT_W'(1);
                end
            end
            ST_POINT: begin
                if (w_expire) begin
                    if (w_win) begin
                        w_next   = ST_OVER;
                        w_winner = r_scorer;
                    end else begin
                        w_next     = ST_SERVE;
                        w_cnt_load = 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_start_d    <= 1'b0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_winner     <= WIN_NONE;
            r_scorer     <= WIN_NONE;
            r_err        <= 1'b0;
            r_to         <= '0;
            r_phys_en    <= 1'b0;
            r_phys_rst_n <= 1'b0;
            r_ops        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_start_d    <= start_btn;
            r_p1         <= w_p1;
            r_p2         <= w_p2;
            r_winner     <= w_winner;
            r_scorer     <= w_scorer;
            r_err        <= w_err;
            r_to         <= w_to;
            r_phys_en    <= w_phys_en;
            r_phys_rst_n <= !(w_next == ST_IDLE || w_next == ST_POINT);
            r_ops        <= (w_next == ST_PLAY) || (w_next == ST_STEP);
        end
    end

    assign phys_en      = r_phys_en;
    assign phys_rst_n   = r_phys_rst_n;
    assign ops_allow    = r_ops;
    assign p1_score     = r_p1;
    assign p2_score     = r_p2;
    assign match_winner = r_winner;
    assign state_o      = r_state;
    assign err          = r_err;

endmodule

// File: tb/tb_match_ctrl.sv
// Randomized bench for match_ctrl against a rally/score-level model.
// Honours MATCH_DEUCE_EN for the expected win rule.
module tb_match_ctrl;

    localparam int WIN = 7;
    localparam int SF  = 60;
    localparam int PF  = 90;
    localparam int VT  = 15;

    logic       clk = 1'b0;
    logic       rst, frame_tick, start_btn;
    logic       phys_valid, phys_game_over;
    logic [1:0] phys_winner;
    logic       phys_en, phys_rst_n, ops_allow, err;
    logic [3:0] p1_score, p2_score;
    logic [1:0] match_winner;
    logic [2:0] state_o;

    match_ctrl #(
        .WIN_SCORE     (WIN),
        .SERVE_FRAMES  (SF),
        .PAUSE_FRAMES  (PF),
        .VALID_TIMEOUT (VT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .start_btn      (start_btn),
        .phys_valid     (phys_valid),
        .phys_game_over (phys_game_over),
        .phys_winner    (phys_winner),
        .phys_en        (phys_en),
        .phys_rst_n     (phys_rst_n),
        .ops_allow      (ops_allow),
        .p1_score       (p1_score),
        .p2_score       (p2_score),
        .match_winner   (match_winner),
        .state_o        (state_o),
        .err            (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    bit force_to = 1'b0;
    bit over;
    int m_p1, m_p2, m_err, m_win;
    int script[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit wins(input int s, input int o);
`ifdef MATCH_DEUCE_EN
        return (s == 15) || (s >= WIN && s - o >= 2);
`else
        return s >= WIN;
`endif
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    task automatic chk_regs(input string tag, input int st);
        chk({tag, "/state"}, int'(state_o), st);
        chk({tag, "/p1"}, int'(p1_score), m_p1);
        chk({tag, "/p2"}, int'(p2_score), m_p2);
        chk({tag, "/winner"}, int'(match_winner), m_win);
        chk({tag, "/err"}, int'(err), m_err);
    endtask

    task automatic model_clear();
        m_p1 = 0; m_p2 = 0; m_err = 0; m_win = 0;
    endtask

    // outputs that follow directly from the current state
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon/rst_n", int'(phys_rst_n),
                int'(!(state_o == 3'd0 || state_o == 3'd4)));
            chk("mon/ops", int'(ops_allow),
                int'(state_o == 3'd2 || state_o == 3'd3));
            if (phys_en) chk("mon/en_state", int'(state_o), 3);
            if (state_o != 3'd5) chk("mon/winner", int'(match_winner), 0);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        model_clear();
        mon_en = 1'b1;
        chk_regs("reset", 0);
        chk("reset/en", int'(phys_en), 0);
        chk("reset/rst_n", int'(phys_rst_n), 0);
        chk("reset/ops", int'(ops_allow), 0);
    endtask

    task automatic press_start();
        start_btn = 1'b0; cyc();
        start_btn = 1'b1; cyc();
        start_btn = 1'b0;
        model_clear();
        chk_regs("start", 1);
    endtask

    task automatic serve_phase();
        for (int i = 1; i <= SF; i++) begin
            idle_gap();
            if (i == SF) chk("serve/ops_pre", int'(ops_allow), 0);
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            if (i < SF) chk("serve/hold", int'(state_o), 1);
        end
        chk("serve/play", int'(state_o), 2);
        chk("serve/ops", int'(ops_allow), 1);
    endtask

    // kind: 0 no game over, 1/2 scorer, 3 bad winner, 4 timeout
    task automatic rally(input int kind, input bit dbl, input bit same);
        int n;
        int exp;
        idle_gap();
        chk("rally/play", int'(state_o), 2);
        frame_tick = 1'b1; cyc(); frame_tick = dbl;
        chk("rally/en1", int'(phys_en), 1);
        cyc(); frame_tick = 1'b0;
        chk("rally/en2", int'(phys_en), 0);
        if (kind == 4) begin
            n = 1;
            while (state_o == 3'd3 && n < 40) begin
                cyc(); n++;
            end
            chk("timeout/cycles", n, VT + 1);
            m_err = 1;
            chk_regs("timeout", 2);
        end else begin
            phys_valid     = 1'b1;
            phys_game_over = (kind != 0);
            if (kind == 1 || kind == 2) phys_winner = 2'(kind);
            else if (kind == 3) phys_winner = $urandom_range(0, 1) ? 2'd3 : 2'd0;
            else phys_winner = 2'($urandom_range(0, 3));
            frame_tick = same;
            cyc();
            phys_valid = 1'b0; phys_game_over = 1'b0;
            phys_winner = 2'd0; frame_tick = 1'b0;
            exp = 2;
            if (kind == 1) begin
                if (m_p1 < 15) m_p1++;
                exp = 4;
            end else if (kind == 2) begin
                if (m_p2 < 15) m_p2++;
                exp = 4;
            end else if (kind == 3) begin
                m_err = 1;
            end
            chk_regs("rally", exp);
            if (exp == 2) begin
                cyc();
                chk("rally/no_en", int'(phys_en), 0);
                chk("rally/still", int'(state_o), 2);
            end
        end
    endtask

    task automatic pause_phase(input int sc, output bit ov);
        int s;
        int o;
        int exp;
        for (int i = 1; i <= PF; i++) begin
            idle_gap();
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            if (i < PF) chk("pause/hold", int'(state_o), 4);
        end
        s = (sc == 1) ? m_p1 : m_p2;
        o = (sc == 1) ? m_p2 : m_p1;
        ov = wins(s, o);
        if (ov) begin
            m_win = sc;
            exp = 5;
        end else begin
            exp = 1;
        end
        chk_regs("pause_end", exp);
    endtask

    task automatic play_match(input bit rnd, output bit ov);
        int pts;
        int sc;
        int r;
        pts = 0;
        ov = 1'b0;
        while (!ov && pts < 40 && (rnd || script.size() > 0)) begin
            serve_phase();
            repeat ($urandom_range(0, 2)) begin
                r = $urandom_range(0, 9);
                rally((r < 6) ? 0 : (r < 9) ? 3 : 4,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            if (force_to) begin
                rally(4, 1'b0, 1'b0);
                force_to = 1'b0;
            end
            if (script.size() > 0) sc = script.pop_front();
            else sc = $urandom_range(1, 2);
            rally(sc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            pause_phase(sc, ov);
            pts++;
        end
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; start_btn = 1'b0;
        phys_valid = 1'b0; phys_game_over = 1'b0; phys_winner = 2'd0;
        model_clear();
        do_reset();

        press_start();
        serve_phase();
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        chk("mid_rst/en_pre", int'(phys_en), 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        model_clear();
        chk_regs("mid_rst", 0);
        chk("mid_rst/en", int'(phys_en), 0);

        press_start();
        script = '{2, 1, 1, 1, 1, 1, 1};
        force_to = 1'b1;
        play_match(1'b0, over);
        start_btn = 1'b1;
        script = '{1};
        play_match(1'b0, over);
        chk("p1win/over", int'(over), 1);
        frame_tick = 1'b1;
        repeat (8) cyc();
        frame_tick = 1'b0;
        chk_regs("over_hold", 5);
        start_btn = 1'b0; cyc();
        press_start();

        script = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 1};
        play_match(1'b0, over);
        script.delete();
        chk("deuce/over", int'(over), 1);
        chk("deuce/winner", int'(match_winner), 1);

        repeat (2) begin
            press_start();
            play_match(1'b1, over);
            chk("rnd/over", int'(over), 1);
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
